// File: rtl/vid_timing_ctrl.sv
// Video timing / test-pattern generator driving rgb2gray vid_in_* ports.
// Ports: CLK, RESETN, run, pat_sel, solid_rgb -> vid_*, busy, frame_done, frame_count.
module vid_timing_ctrl #(
  parameter int          H_ACTIVE  = 1280,
  parameter int          H_BLANK   = 100,
  parameter int          V_ACTIVE  = 720,
  parameter int          V_BLANK   = 1380,
  parameter logic [23:0] RAMP_STEP = 24'h0a0a0a
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        run,
  input  logic        pat_sel,
  input  logic [23:0] solid_rgb,
  output logic        vid_active,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic [23:0] vid_rgb,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] HA_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

  typedef enum logic [1:0] {
    IDLE,
    HBLANK,
    ACTIVE,
    VBLANK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] h_cnt, h_cnt_d;
  logic [15:0] line_cnt, line_cnt_d;
  logic [15:0] vb_cnt, vb_cnt_d;
  logic        solid_q, solid_d;
  logic [23:0] rgb_d;
  logic        done_d;

  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt;
    line_cnt_d = line_cnt;
    vb_cnt_d   = vb_cnt;
    solid_d    = solid_q;
    rgb_d      = vid_rgb;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = HBLANK;
          h_cnt_d    = '0;
          line_cnt_d = '0;
        end
      end
      HBLANK: begin
        if (h_cnt == HB_LAST) begin
          state_d = ACTIVE;
          h_cnt_d = '0;
          solid_d = pat_sel;
          rgb_d   = pat_sel ? solid_rgb : '0;
        end else begin
          h_cnt_d = h_cnt + 16'd1;
        end
      end
      ACTIVE: begin
        if (h_cnt == HA_LAST) begin
          h_cnt_d = '0;
          if (line_cnt == VA_LAST) begin
            state_d  = VBLANK;
            vb_cnt_d = '0;
          end else begin
            state_d    = HBLANK;
            line_cnt_d = line_cnt + 16'd1;
          end
        end else begin
          h_cnt_d = h_cnt + 16'd1;
          // last pixel is not advanced so the blank-time hold shows it
          if (!solid_q) rgb_d = vid_rgb + RAMP_STEP;
        end
      end
      VBLANK: begin
        if (vb_cnt == VB_LAST) begin
          vb_cnt_d = '0;
          if (run) begin
            state_d    = HBLANK;
            h_cnt_d    = '0;
            line_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          vb_cnt_d = vb_cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs registered from next-state so they line up with the state
  assign done_d = (state_d == VBLANK) && (vb_cnt_d == VB_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      h_cnt       <= '0;
      line_cnt    <= '0;
      vb_cnt      <= '0;
      solid_q     <= 1'b0;
      vid_rgb     <= '0;
      vid_active  <= 1'b0;
      vid_hsync   <= 1'b0;
      vid_vsync   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      h_cnt       <= h_cnt_d;
      line_cnt    <= line_cnt_d;
      vb_cnt      <= vb_cnt_d;
      solid_q     <= solid_d;
      vid_rgb     <= rgb_d;
      vid_active  <= (state_d == ACTIVE);
      vid_hsync   <= (state_d == ACTIVE);
      vid_vsync   <= (state_d == HBLANK) ||
                     (state_d == ACTIVE);
      busy        <= (state_d != IDLE);
      frame_done  <= done_d;
      frame_count <= frame_count + {15'd0, done_d};
    end
  end

endmodule
